// File: rtl/layer1_window_gen.sv
// layer1_window_gen: 3x3 sliding-window generator for the layer-1 convolution stage.
// Accepts a raster-order pixel stream and emits complete windows over a
// valid/ready handshake, tagged with the window's top-left row/column.
// Optional feature macro: LAYER1_WIN_COUNT_EN adds a per-frame window counter
// output (win_count); without it the port and counter are absent.
`timescale 1ns/1ps
module layer1_window_gen #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_ready,
  output logic                       win_valid,
  output logic [9*DATA_W-1:0]        win_data,
  input  logic                       win_ready,
  output logic [$clog2(IMG_H)-1:0]   win_row,
  output logic [$clog2(IMG_W)-1:0]   win_col,
`ifdef LAYER1_WIN_COUNT_EN
  output logic [15:0]                win_count,
`endif
  output logic                       frame_done
);

  localparam int          RW   = $clog2(IMG_H);
  localparam int          CW   = $clog2(IMG_W);
  localparam int unsigned LB_D = IMG_W - 3;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_STREAM,
    S_FLUSH
  } state_t;

  state_t state, state_n;

  logic [DATA_W-1:0] w    [3][3];
  logic [DATA_W-1:0] nw   [3][3];
  logic [DATA_W-1:0] lb_a [LB_D];
  logic [DATA_W-1:0] lb_b [LB_D];

  logic [CW-1:0]       col;
  logic [RW-1:0]       row;
  logic [9*DATA_W-1:0] win_next;
  logic                accept;
  logic                win_hs;
  logic                col_last;
  logic                row_last;
  logic                last_pix;
  logic                win_complete;
  logic                frame_done_n;

  assign accept       = in_valid && in_ready;
  assign win_hs       = win_valid && win_ready;
  assign col_last     = (col == COL_LAST);
  assign row_last     = (row == ROW_LAST);
  assign last_pix     = col_last && row_last;
  assign win_complete = accept && (row >= RW'(2)) && (col >= CW'(2));

  // Window contents after the shift that the current pixel would cause.
  always_comb begin
    nw[2][2] = in_data;
    nw[2][1] = w[2][2];
    nw[2][0] = w[2][1];
    nw[1][2] = lb_b[LB_D-1];
    nw[1][1] = w[1][2];
    nw[1][0] = w[1][1];
    nw[0][2] = lb_a[LB_D-1];
    nw[0][1] = w[0][2];
    nw[0][0] = w[0][1];
    win_next = '0;
    for (int unsigned r = 0; r < 3; r++) begin
      for (int unsigned c = 0; c < 3; c++) begin
        win_next[DATA_W*(3*r+c) +: DATA_W] = nw[r][c];
      end
    end
  end

  // Window column registers advance one pixel per accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < 3; r++) begin
        for (int unsigned c = 0; c < 3; c++) begin
          w[r][c] <= '0;
        end
      end
    end else if (accept) begin
      for (int unsigned r = 0; r < 3; r++) begin
        for (int unsigned c = 0; c < 3; c++) begin
          w[r][c] <= nw[r][c];
        end
      end
    end
  end

  // Row delay lines: oldest entry of each feeds the right column of the row above.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < LB_D; i++) begin
        lb_a[i] <= '0;
        lb_b[i] <= '0;
      end
    end else if (accept) begin
      lb_a[0] <= w[1][0];
      lb_b[0] <= w[2][0];
      for (int unsigned i = 1; i < LB_D; i++) begin
        lb_a[i] <= lb_a[i-1];
        lb_b[i] <= lb_b[i-1];
      end
    end
  end

  // Raster position of the pixel being accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Output window register: loads on completion, holds until consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_valid <= 1'b0;
      win_data  <= '0;
      win_row   <= '0;
      win_col   <= '0;
    end else if (win_complete) begin
      win_valid <= 1'b1;
      win_data  <= win_next;
      win_row   <= row - RW'(2);
      win_col   <= col - CW'(2);
    end else if (win_ready) begin
      win_valid <= 1'b0;
    end
  end

  // FSM state and frame_done pulse register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      frame_done <= frame_done_n;
    end
  end

  // FSM next-state and input back-pressure.
  always_comb begin
    state_n      = state;
    frame_done_n = 1'b0;
    in_ready     = (state != S_FLUSH) && !(win_valid && !win_ready);
    case (state)
      S_IDLE: begin
        if (accept) state_n = S_FILL;
      end
      S_FILL: begin
        if (accept && (row == RW'(2)) && (col == '0)) state_n = S_STREAM;
      end
      S_STREAM: begin
        if (accept && last_pix) state_n = S_FLUSH;
      end
      S_FLUSH: begin
        if (win_hs) begin
          state_n      = S_IDLE;
          frame_done_n = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

`ifdef LAYER1_WIN_COUNT_EN
  logic [15:0] cnt_q;

  // Count window handshakes; the final handshake of a frame clears the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (win_hs && (state == S_FLUSH)) begin
      cnt_q <= '0;
    end else if (win_hs) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  // Output includes the in-flight handshake so the final total shows in the
  // cycle before frame_done, while the register is already 0 on frame_done.
  assign win_count = cnt_q + 16'(win_hs);
`endif

endmodule

// File: tb/tb_layer1_window_gen.sv
// Self-checking bench for layer1_window_gen (IMG_W=5, IMG_H=5, DATA_W=16).
// A negedge monitor models the pixel image and pushes each expected window to a
// scoreboard on accept; handshaken windows are popped and compared.
`timescale 1ns/1ps
module tb_layer1_window_gen;
  localparam int DW = 16;
  localparam int IW = 5;
  localparam int IH = 5;
  localparam int WW = 9*DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          win_valid;
  logic [WW-1:0] win_data;
  logic          win_ready;
  logic [2:0]    win_row;
  logic [2:0]    win_col;
  logic          frame_done;

  always #5 clk = ~clk;

  layer1_window_gen #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .win_valid(win_valid), .win_data(win_data),
    .win_ready(win_ready), .win_row(win_row), .win_col(win_col),
    .frame_done(frame_done)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [WW-1:0] pk(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    logic [WW-1:0] res;
    int v[9];
    v = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
    res = '0;
    for (int i = 0; i < 9; i++) res[DW*i +: DW] = DW'(v[i]);
    return res;
  endfunction

  typedef struct {
    logic [WW-1:0] d;
    int            r;
    int            c;
  } win_t;

  win_t          sb[$];
  logic [WW-1:0] seen[$];
  logic [DW-1:0] img[IH][IW];
  int            mr = 0, mc = 0, fd_cnt = 0;
  bit            m_flush = 0, exp_v = 0, exp_fd = 0, held = 0;
  logic [WW-1:0] held_d;

  // Monitor / scoreboard
  always @(negedge clk) begin
    win_t e;
    if (rst) begin
      sb.delete();
      mr = 0; mc = 0;
      m_flush = 0; exp_v = 0; exp_fd = 0; held = 0;
    end else begin
      if (exp_v) chk("win_latency", win_valid, 1);
      chk("frame_done", frame_done, exp_fd);
      if (frame_done) fd_cnt++;
      chk("in_ready", in_ready, !(win_valid && !win_ready) && !m_flush);
      if (held) begin
        chk("hold_valid", win_valid, 1);
        chk("hold_data", win_data, held_d);
      end
      exp_v = 0; exp_fd = 0;
      held = win_valid && !win_ready;
      held_d = win_data;
      if (win_valid && win_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_win: got window %0h expected none", win_data);
        end else begin
          e = sb.pop_front();
          if (win_data !== e.d || int'(win_row) != e.r || int'(win_col) != e.c) begin
            errors++;
            $display("FAIL win: got (%0d,%0d) %0h expected (%0d,%0d) %0h",
                     win_row, win_col, win_data, e.r, e.c, e.d);
          end
        end
        seen.push_back(win_data);
        if (m_flush) begin m_flush = 0; exp_fd = 1; end
      end
      if (in_valid && in_ready) begin
        img[mr][mc] = in_data;
        if (mr >= 2 && mc >= 2) begin
          e.d = '0;
          for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
              e.d[DW*(3*r+c) +: DW] = img[mr-2+r][mc-2+c];
          e.r = mr - 2;
          e.c = mc - 2;
          sb.push_back(e);
          exp_v = 1;
        end
        if (mr == IH-1 && mc == IW-1) m_flush = 1;
        if (mc == IW-1) begin mc = 0; mr = (mr == IH-1) ? 0 : mr + 1; end
        else mc++;
      end
    end
  end

  // Drive the first npix pixels of a frame (pixel = base+5*row+col), gap_pct% idle cycles.
  task automatic send_frame(input int base, input int gap_pct, input int npix);
    int r, c, tmo;
    bit done;
    r = 0; c = 0;
    for (int k = 0; k < npix; k++) begin
      done = 0; tmo = 0;
      while (!done) begin
        if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
          in_valid = 1'b0;
        end else begin
          in_valid = 1'b1;
          in_data  = DW'(base + 5*r + c);
        end
        @(negedge clk);
        done = in_valid && in_ready;
        @(posedge clk); #1;
        tmo++;
        if (tmo > 200) begin
          errors++;
          $display("FAIL accept_timeout: got no accept for pixel %0d expected accept within 200 cycles", k);
          $display("Result: errors=%0d of %0d checks", errors, checks);
          $fatal(1, "accept timeout");
        end
      end
      if (c == 4) begin c = 0; r++; end
      else c++;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_fd(input int n);
    for (int t = 0; t < 100 && fd_cnt < n; t++) @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
  endtask

  typedef struct {
    string         name;
    int            gap;
    int            stall;
    logic [WW-1:0] first;
    logic [WW-1:0] second;
    logic [WW-1:0] last;
    int            nwin;
  } scen_t;

  scen_t tbl[3];

  initial begin
    logic [WW-1:0] w00, w01, w22;
    w00 = pk(0, 1, 2, 5, 6, 7, 10, 11, 12);
    w01 = pk(1, 2, 3, 6, 7, 8, 11, 12, 13);
    w22 = pk(12, 13, 14, 17, 18, 19, 22, 23, 24);
    tbl[0] = '{"continuous", 0,  0, w00, w01, w22, 9};
    tbl[1] = '{"stall4",     0,  4, w00, w01, w22, 9};
    tbl[2] = '{"gaps50",     50, 0, w00, w01, w22, 9};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; win_ready = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_win_data", win_data, 0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 3; i++) begin
      seen.delete();
      fd_cnt = 0;
      if (tbl[i].stall > 0) begin
        win_ready = 1'b0;
        fork
          send_frame(0, tbl[i].gap, 25);
          begin
            int t;
            t = 0;
            while (!win_valid && t < 200) begin @(negedge clk); t++; end
            for (int k = 0; k < tbl[i].stall; k++) begin
              @(negedge clk);
              chk("stall_in_ready", in_ready, 0);
              chk("stall_hold", win_data, tbl[i].first);
            end
            @(posedge clk); #1 win_ready = 1'b1;
          end
        join
      end else begin
        win_ready = 1'b1;
        send_frame(0, tbl[i].gap, 25);
      end
      wait_fd(1);
      chk({tbl[i].name, "_nwin"}, seen.size(), tbl[i].nwin);
      chk({tbl[i].name, "_first"}, seen[0], tbl[i].first);
      chk({tbl[i].name, "_second"}, seen[1], tbl[i].second);
      chk({tbl[i].name, "_last"}, seen[seen.size()-1], tbl[i].last);
      chk({tbl[i].name, "_fd_cnt"}, fd_cnt, 1);
      chk({tbl[i].name, "_sb_empty"}, sb.size(), 0);
    end

    // Two back-to-back frames
    seen.delete();
    fd_cnt = 0;
    win_ready = 1'b1;
    send_frame(0, 0, 25);
    send_frame(100, 0, 25);
    wait_fd(2);
    chk("b2b_nwin", seen.size(), 18);
    chk("b2b_f1_last", seen[8], w22);
    chk("b2b_f2_first", seen[9], pk(100, 101, 102, 105, 106, 107, 110, 111, 112));
    chk("b2b_fd_cnt", fd_cnt, 2);

    // Reset mid-frame after pixel 17
    send_frame(0, 0, 18);
    chk("pre_rst_valid", win_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_win_valid", win_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_win_data", win_data, 0);
    chk("mid_rst_win_row", win_row, 0);
    chk("mid_rst_win_col", win_col, 0);
    chk("mid_rst_frame_done", frame_done, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    seen.delete();
    fd_cnt = 0;
    send_frame(0, 0, 25);
    wait_fd(1);
    chk("post_rst_first", seen[0], w00);
    chk("post_rst_nwin", seen.size(), 9);
    chk("post_rst_fd_cnt", fd_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/layer1_window_gen.md
Name: layer1_window_gen

Overview:
- Upstream feeder for the layer-1 convolution stage. Turns a raster-order pixel stream into 3x3 sliding windows.
- Holds two row delay lines internally, each IMG_W-3 entries deep. The 3 window column registers per row make each row tap span exactly IMG_W pixels.
- The window is emitted with a valid/ready handshake to the layer-1 MAC array, along with position and end-of-frame information.

Parameters:
- DATA_W, 16, pixel width in bits.
- IMG_W, 32, frame width in pixels; must be >= 4.
- IMG_H, 32, frame height in pixels; must be >= 3.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  pixel present on in_data.
- in_data  input  DATA_W  pixel, raster order, row-major.
- in_ready  output  1  block can accept a pixel this cycle.
- win_valid  output  1  win_data holds a complete window.
- win_data  output  9*DATA_W  window; slice [DATA_W*(3*r+c) +: DATA_W] = pixel (win_row+r, win_col+c), with r,c in 0..2.
- win_ready  input  1  consumer accepts the window.
- win_row  output  $clog2(IMG_H)  top-left row of the window.
- win_col  output  $clog2(IMG_W)  top-left column of the window.
- frame_done  output  1  one-cycle pulse after the last window of a frame is accepted.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset: every output, counter, window register, line-buffer entry and the FSM go to 0 / S_IDLE. After reset, in_ready=1, win_valid=0, frame_done=0.
- Accept: a pixel is accepted when in_valid && in_ready. in_ready = !(win_valid && !win_ready), so the block can accept in the same cycle the held window is consumed.
- Datapath shift (only on accept):
  - pixel -> w[2][2]; w[r][2] -> w[r][1] -> w[r][0].
  - w[2][0] -> line buffer B (depth IMG_W-3); B output -> w[1][2].
  - w[1][0] -> line buffer A (depth IMG_W-3); A output -> w[0][2].
- Counters col (0..IMG_W-1) and row (0..IMG_H-1) track the accepted pixel. col wraps to 0 and row increments at col=IMG_W-1. Both wrap to 0 after pixel (IMG_H-1, IMG_W-1).
- Window emit: an accepted pixel with row>=2 && col>=2 completes a window.
  - On the next edge: win_valid=1, win_data = the shifted window, win_row=row-2, win_col=col-2. Latency is 1 cycle from accept to win_valid.
  - win_valid holds, with all win outputs stable, until win_ready. It clears on handshake unless a new window completes in the same cycle.
- FSM:
  - S_IDLE: first accept of a frame -> S_FILL.
  - S_FILL: rows 0-1 being loaded; an accept at (2,0) -> S_STREAM.
  - S_STREAM: an accept of the last pixel -> S_FLUSH.
  - S_FLUSH: last window pending; win handshake -> S_IDLE, frame_done=1 for one cycle.
  - In S_FLUSH, in_ready=0 until the handshake. No pixel of the next frame is accepted before frame_done.
- Line buffers are not cleared between frames. Stale data never appears in an emitted window because emission is gated by row>=2 && col>=2.
- in_valid with in_ready=0: no state change; the pixel is held by the producer.
- Reset mid-frame: all state is discarded. The next accepted pixel is (0,0).

Optional Feature:
- Macro: LAYER1_WIN_COUNT_EN.
- Defined: adds output win_count [15:0]. It increments on each window handshake, resets to 0 on rst, and clears to 0 in the cycle frame_done is asserted (the final count is visible the cycle before).
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan (IMG_W=5, IMG_H=5, DATA_W=16, pixel = 5*row+col unless noted):
- Continuous stream, win_ready=1 -> first win_valid 1 cycle after pixel 12 is accepted; win_data = {0,1,2,5,6,7,10,11,12}, win_row=0, win_col=0. 9 windows total; last = {12,13,14,17,18,19,22,23,24} at (2,2); frame_done pulses once.
- win_ready=0 for 4 cycles while window (0,0) is pending -> in_ready=0; window (0,0) holds; no pixel lost. After release, the next window is (0,1) = {1,2,3,6,7,8,11,12,13}.
- Random in_valid gaps (50%) -> same 9 windows in the same order as the continuous case.
- Two back-to-back frames, second frame pixel = 100+5*row+col -> first window of frame 2 = {100,101,102,105,106,107,110,111,112}; no frame-1 data leaks; 2 frame_done pulses.
- rst asserted after pixel 17 -> outputs 0 immediately. A fresh frame afterwards yields window (0,0) = {0,1,2,5,6,7,10,11,12}.
- With LAYER1_WIN_COUNT_EN -> win_count reads 9 the cycle before frame_done, and 0 on frame_done.
